snoop_controller: RTL and testbench
===================================

# snoop_controller

Bus-side MSI snoop responder for one cache line. It accepts snooped bus transactions and checks them against the line's current state, address and data. On a hit it writes back Modified data to memory when the protocol requires it, then rewrites the line through the line's write/state/address/data port. It sits between the coherence bus and the single-line cache store, and is the only agent that downgrades or invalidates that line on behalf of other processors.

## Interface
- ADDR_W, 3, line/bus address width
- DATA_W, 4, line data width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- bus_valid  in  1  snooped transaction present
- bus_op  in  2  00 none, 01 read_miss, 10 write_miss, 11 invalidate
- bus_address  in  ADDR_W  snooped address
- bus_ready  out  1  controller idle, can accept
- line_state  in  2  line state: 00 I, 01 S, 10 M, 11 reserved (treated as I)
- line_address  in  ADDR_W  line tag/address
- line_data  in  DATA_W  line data
- line_write  out  1  one-cycle write strobe to line
- line_state_out  out  2  new state
- line_address_out  out  ADDR_W  address written (captured line address)
- line_data_out  out  DATA_W  data written (captured line data)
- wb_valid  out  1  writeback request to memory
- wb_address  out  ADDR_W  writeback address
- wb_data  out  DATA_W  writeback data
- wb_ack  in  1  memory accepted writeback
- done  out  1  one-cycle completion pulse
- hit  out  1  valid with done: transaction matched a valid line
- protocol_error  out  1  valid with done: invalidate hit a Modified line

## Operation
- FSM states: IDLE, LOOKUP, WRITEBACK, UPDATE, DONE.
- IDLE: bus_ready=1. On bus_valid&&bus_ready, capture bus_op and bus_address, then go to LOOKUP.
- LOOKUP: sample line_state, line_address and line_data into snapshot registers. A hit requires address equal and state S or M. Next-state decision:
  - miss, or op 00 -> DONE; no line write.
  - read_miss, S -> DONE; hit=1, no change.
  - read_miss, M -> WRITEBACK; new state S.
  - write_miss, M -> WRITEBACK; new state I.
  - write_miss, S -> UPDATE; new state I.
  - invalidate, S -> UPDATE; new state I.
  - invalidate, M -> UPDATE; new state I, no writeback, protocol_error=1.
- WRITEBACK: wb_valid=1 with snapshot address and data, held stable until wb_ack is sampled high. Then go to UPDATE.
- UPDATE: line_write=1 for exactly one cycle with the new state, snapshot address and snapshot data. Then go to DONE.
- DONE: done=1 for one cycle, with hit and protocol_error valid. Then go to IDLE.
- Transactions arriving while bus_ready=0 are ignored; there is no queueing.
- wb_ack outside WRITEBACK is ignored.
- The line is never written on a miss. Line data is never modified; only the state is downgraded.

## Timing
- All outputs are registered or decoded from FSM state.
- Reset values: all outputs 0 except bus_ready=1. FSM=IDLE and snapshots are cleared.
- Reset asserted mid-operation:
  - the FSM returns to IDLE immediately and wb_valid drops;
  - a pending line_write is cancelled, so the line keeps its old contents;
  - no done pulse is produced.
- Let accept edge = cycle 0. Latency:
  - miss: done in cycle 2;
  - hit without writeback: line_write in cycle 2, done in cycle 3;
  - hit with writeback: wb_valid from cycle 2; if ack is sampled at the end of cycle k, line_write is in cycle k+1 and done in cycle k+2.
- bus_ready is low from cycle 1 through the DONE cycle. It is high again the cycle after done.
- The line inputs are sampled only in LOOKUP. Later changes to them do not affect writeback data.

## Structure
- coherence_pkg holds:
  - state encodings: STATE_I, STATE_S, STATE_M;
  - bus op encodings: OP_NONE, OP_READ_MISS, OP_WRITE_MISS, OP_INVALIDATE;
  - the FSM state typedef.
- Single module, no sub-module. The hit comparison and the next-state decode are a combinational block inside it.
- The line store is instantiated by the parent. Its write/state/address/data_in inputs are fed from line_write/line_state_out/line_address_out/line_data_out.

## Test plan
- Line M, addr 5, data A. read_miss addr 5, wb_ack after 3 cycles:
  - wb_valid held with 5/A until the ack;
  - then line_write with state S, addr 5, data A;
  - then done with hit=1.
- Line S, addr 2. write_miss addr 2 -> no wb_valid; line_write with state I in cycle 2; done in cycle 3.
- Line M, addr 1. read_miss addr 6 -> miss; done in cycle 2 with hit=0; no line_write, no wb_valid.
- Line M, addr 3. invalidate addr 3 -> line_write with state I and no writeback; done with protocol_error=1.
- Line M, addr 7. write_miss addr 7; reset asserted while wb_valid is high:
  - wb_valid drops asynchronously;
  - no line_write and no done;
  - bus_ready=1 after reset.
- A second bus_valid presented during WRITEBACK is ignored; only the first transaction completes, and bus_ready=1 after done.

Source files
------------

// File: rtl/coherence_pkg.sv
// Shared MSI coherence encodings and the snoop responder FSM state type.
package coherence_pkg;

    localparam logic [1:0] STATE_I = 2'b00;
    localparam logic [1:0] STATE_S = 2'b01;
    localparam logic [1:0] STATE_M = 2'b10;

    localparam logic [1:0] OP_NONE       = 2'b00;
    localparam logic [1:0] OP_READ_MISS  = 2'b01;
    localparam logic [1:0] OP_WRITE_MISS = 2'b10;
    localparam logic [1:0] OP_INVALIDATE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_UPDATE    = 3'd3,
        ST_DONE      = 3'd4
    } snoop_fsm_t;

    // The reserved encoding 2'b11 counts as invalid.
    function automatic logic is_valid_state(input logic [1:0] state);
        return (state == STATE_S) || (state == STATE_M);
    endfunction

endpackage

// File: rtl/snoop_controller.sv
// MSI snoop responder for a single cache line: looks up a snooped bus op,
// writes back Modified data if needed, then downgrades/invalidates the line.
//
// state     | meaning
// IDLE      | ready for a bus transaction
// LOOKUP    | snapshot line, decide hit and action
// WRITEBACK | hold writeback request until wb_ack
// UPDATE    | one-cycle line write with the new state
// DONE      | one-cycle completion pulse with hit/protocol_error
module snoop_controller
    import coherence_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus_valid,
    input  logic [1:0]        bus_op,
    input  logic [ADDR_W-1:0] bus_address,
    output logic              bus_ready,
    input  logic [1:0]        line_state,
    input  logic [ADDR_W-1:0] line_address,
    input  logic [DATA_W-1:0] line_data,
    output logic              line_write,
    output logic [1:0]        line_state_out,
    output logic [ADDR_W-1:0] line_address_out,
    output logic [DATA_W-1:0] line_data_out,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_address,
    output logic [DATA_W-1:0] wb_data,
    input  logic              wb_ack,
    output logic              done,
    output logic              hit,
    output logic              protocol_error
);

    snoop_fsm_t        r_state;
    snoop_fsm_t        w_next;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [ADDR_W-1:0] r_snap_addr;
    logic [DATA_W-1:0] r_snap_data;
    logic [1:0]        r_new_state;
    logic              r_hit;
    logic              r_perr;

    logic              w_match;
    logic              w_hit;
    logic              w_perr;
    logic [1:0]        w_new_state;

    assign w_match = is_valid_state(line_state) && (line_address == r_bus_addr);

    always_comb begin
        w_next      = r_state;
        w_hit       = 1'b0;
        w_perr      = 1'b0;
        w_new_state = STATE_I;
        unique case (r_state)
            ST_IDLE: begin
                if (bus_valid) begin
                    w_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                w_next = ST_DONE;
                if (w_match && (r_op != OP_NONE)) begin
                    w_hit = 1'b1;
                    case (r_op)
                        OP_READ_MISS: begin
                            if (line_state == STATE_M) begin
                                w_next      = ST_WRITEBACK;
                                w_new_state = STATE_S;
                            end
                        end
                        OP_WRITE_MISS: begin
                            w_next      = (line_state == STATE_M) ? ST_WRITEBACK : ST_UPDATE;
                            w_new_state = STATE_I;
                        end
                        OP_INVALIDATE: begin
                            // A Modified line here means another cache wrote without owning it.
                            w_next      = ST_UPDATE;
                            w_new_state = STATE_I;
                            w_perr      = (line_state == STATE_M);
                        end
                        default: begin
                            w_next = ST_DONE;
                        end
                    endcase
                end
            end
            ST_WRITEBACK: begin
                if (wb_ack) begin
                    w_next = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op        <= OP_NONE;
            r_bus_addr  <= '0;
            r_snap_addr <= '0;
            r_snap_data <= '0;
            r_new_state <= STATE_I;
            r_hit       <= 1'b0;
            r_perr      <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && bus_valid) begin
                r_op       <= bus_op;
                r_bus_addr <= bus_address;
            end
            // Line inputs are only trusted here; later changes must not leak into writeback.
            if (r_state == ST_LOOKUP) begin
                r_snap_addr <= line_address;
                r_snap_data <= line_data;
                r_new_state <= w_new_state;
                r_hit       <= w_hit;
                r_perr      <= w_perr;
            end
        end
    end

    assign bus_ready        = (r_state == ST_IDLE);
    assign wb_valid         = (r_state == ST_WRITEBACK);
    assign wb_address       = r_snap_addr;
    assign wb_data          = r_snap_data;
    assign line_write       = (r_state == ST_UPDATE);
    assign line_state_out   = r_new_state;
    assign line_address_out = r_snap_addr;
    assign line_data_out    = r_snap_data;
    assign done             = (r_state == ST_DONE);
    assign hit              = (r_state == ST_DONE) && r_hit;
    assign protocol_error   = (r_state == ST_DONE) && r_perr;

endmodule

// File: tb/tb_snoop_controller.sv
// Directed bench for snoop_controller with cycle-exact hand-computed expectations.
module tb_snoop_controller;
    import coherence_pkg::*;

    localparam int AW = 3;
    localparam int DW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          bus_valid;
    logic [1:0]    bus_op;
    logic [AW-1:0] bus_address;
    logic          bus_ready;
    logic [1:0]    line_state;
    logic [AW-1:0] line_address;
    logic [DW-1:0] line_data;
    logic          line_write;
    logic [1:0]    line_state_out;
    logic [AW-1:0] line_address_out;
    logic [DW-1:0] line_data_out;
    logic          wb_valid;
    logic [AW-1:0] wb_address;
    logic [DW-1:0] wb_data;
    logic          wb_ack;
    logic          done;
    logic          hit;
    logic          protocol_error;

    int n_vec  = 0;
    int n_miss = 0;

    snoop_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock            (clock),
        .reset            (reset),
        .bus_valid        (bus_valid),
        .bus_op           (bus_op),
        .bus_address      (bus_address),
        .bus_ready        (bus_ready),
        .line_state       (line_state),
        .line_address     (line_address),
        .line_data        (line_data),
        .line_write       (line_write),
        .line_state_out   (line_state_out),
        .line_address_out (line_address_out),
        .line_data_out    (line_data_out),
        .wb_valid         (wb_valid),
        .wb_address       (wb_address),
        .wb_data          (wb_data),
        .wb_ack           (wb_ack),
        .done             (done),
        .hit              (hit),
        .protocol_error   (protocol_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_line(input logic [1:0] st, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        line_state   = st;
        line_address = addr;
        line_data    = data;
    endtask

    // Presents one transaction for the accept edge; returns in cycle 1.
    task automatic start(input logic [1:0] op, input logic [AW-1:0] addr);
        bus_valid   = 1'b1;
        bus_op      = op;
        bus_address = addr;
        tick();
        bus_valid   = 1'b0;
        bus_op      = OP_NONE;
    endtask

    initial begin
        reset       = 1'b1;
        bus_valid   = 1'b0;
        bus_op      = OP_NONE;
        bus_address = '0;
        wb_ack      = 1'b0;
        set_line(STATE_I, 3'd0, 4'h0);
        tick();
        tick();
        chk("rst_ready", 32'(bus_ready), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_line_write", 32'(line_write), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_perr", 32'(protocol_error), 0);
        chk("rst_state_out", 32'(line_state_out), 0);
        chk("rst_wb_data", 32'(wb_data), 0);
        reset = 1'b0;
        tick();

        // read_miss hit on M: writeback, downgrade to S
        set_line(STATE_M, 3'd5, 4'hA);
        start(OP_READ_MISS, 3'd5);
        chk("t1_c1_ready", 32'(bus_ready), 0);
        chk("t1_c1_wb", 32'(wb_valid), 0);
        tick();
        line_data = 4'h3;
        chk("t1_c2_wb", 32'(wb_valid), 1);
        chk("t1_c2_wb_addr", 32'(wb_address), 5);
        chk("t1_c2_wb_data", 32'(wb_data), 32'hA);
        chk("t1_c2_lw", 32'(line_write), 0);
        for (int c = 3; c <= 5; c++) begin
            tick();
            chk($sformatf("t1_c%0d_wb", c), 32'(wb_valid), 1);
            chk($sformatf("t1_c%0d_wb_data", c), 32'(wb_data), 32'hA);
            chk($sformatf("t1_c%0d_lw", c), 32'(line_write), 0);
        end
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        chk("t1_c6_lw", 32'(line_write), 1);
        chk("t1_c6_state", 32'(line_state_out), 1);
        chk("t1_c6_addr", 32'(line_address_out), 5);
        chk("t1_c6_data", 32'(line_data_out), 32'hA);
        chk("t1_c6_wb", 32'(wb_valid), 0);
        chk("t1_c6_done", 32'(done), 0);
        tick();
        chk("t1_c7_done", 32'(done), 1);
        chk("t1_c7_hit", 32'(hit), 1);
        chk("t1_c7_perr", 32'(protocol_error), 0);
        chk("t1_c7_lw", 32'(line_write), 0);
        chk("t1_c7_ready", 32'(bus_ready), 0);
        tick();
        chk("t1_c8_ready", 32'(bus_ready), 1);
        chk("t1_c8_done", 32'(done), 0);

        // write_miss hit on S: invalidate without writeback
        set_line(STATE_S, 3'd2, 4'h6);
        start(OP_WRITE_MISS, 3'd2);
        tick();
        chk("t2_c2_lw", 32'(line_write), 1);
        chk("t2_c2_state", 32'(line_state_out), 0);
        chk("t2_c2_addr", 32'(line_address_out), 2);
        chk("t2_c2_data", 32'(line_data_out), 6);
        chk("t2_c2_wb", 32'(wb_valid), 0);
        chk("t2_c2_done", 32'(done), 0);
        tick();
        chk("t2_c3_done", 32'(done), 1);
        chk("t2_c3_hit", 32'(hit), 1);
        chk("t2_c3_lw", 32'(line_write), 0);
        tick();
        chk("t2_c4_ready", 32'(bus_ready), 1);

        // address miss
        set_line(STATE_M, 3'd1, 4'hC);
        start(OP_READ_MISS, 3'd6);
        chk("t3_c1_lw", 32'(line_write), 0);
        tick();
        chk("t3_c2_done", 32'(done), 1);
        chk("t3_c2_hit", 32'(hit), 0);
        chk("t3_c2_lw", 32'(line_write), 0);
        chk("t3_c2_wb", 32'(wb_valid), 0);
        tick();
        chk("t3_c3_ready", 32'(bus_ready), 1);
        chk("t3_c3_done", 32'(done), 0);

        // invalidate on M: protocol error, no writeback
        set_line(STATE_M, 3'd3, 4'h5);
        start(OP_INVALIDATE, 3'd3);
        tick();
        chk("t4_c2_lw", 32'(line_write), 1);
        chk("t4_c2_state", 32'(line_state_out), 0);
        chk("t4_c2_addr", 32'(line_address_out), 3);
        chk("t4_c2_wb", 32'(wb_valid), 0);
        tick();
        chk("t4_c3_done", 32'(done), 1);
        chk("t4_c3_perr", 32'(protocol_error), 1);
        chk("t4_c3_hit", 32'(hit), 1);
        tick();

        // reserved state behaves as invalid
        set_line(2'b11, 3'd4, 4'h1);
        start(OP_READ_MISS, 3'd4);
        tick();
        chk("t5_done", 32'(done), 1);
        chk("t5_hit", 32'(hit), 0);
        chk("t5_lw", 32'(line_write), 0);
        chk("t5_wb", 32'(wb_valid), 0);
        tick();

        // op none on a matching valid line: no line write
        set_line(STATE_S, 3'd0, 4'h2);
        start(OP_NONE, 3'd0);
        tick();
        chk("t6_done", 32'(done), 1);
        chk("t6_lw", 32'(line_write), 0);
        chk("t6_perr", 32'(protocol_error), 0);
        tick();

        // reset during writeback
        set_line(STATE_M, 3'd7, 4'hF);
        start(OP_WRITE_MISS, 3'd7);
        tick();
        chk("t7_c2_wb", 32'(wb_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t7_async_wb", 32'(wb_valid), 0);
        chk("t7_async_ready", 32'(bus_ready), 1);
        tick();
        reset  = 1'b0;
        wb_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            wb_ack = 1'b0;
            chk($sformatf("t7_post%0d_lw", c), 32'(line_write), 0);
            chk($sformatf("t7_post%0d_done", c), 32'(done), 0);
            chk($sformatf("t7_post%0d_ready", c), 32'(bus_ready), 1);
        end

        // second transaction while busy is dropped
        set_line(STATE_M, 3'd4, 4'h9);
        start(OP_READ_MISS, 3'd4);
        bus_valid   = 1'b1;
        bus_op      = OP_WRITE_MISS;
        bus_address = 3'd4;
        tick();
        chk("t8_c2_wb", 32'(wb_valid), 1);
        chk("t8_c2_ready", 32'(bus_ready), 0);
        tick();
        wb_ack = 1'b1;
        chk("t8_c3_wb", 32'(wb_valid), 1);
        tick();
        wb_ack    = 1'b0;
        bus_valid = 1'b0;
        bus_op    = OP_NONE;
        chk("t8_c4_lw", 32'(line_write), 1);
        chk("t8_c4_state", 32'(line_state_out), 1);
        chk("t8_c4_data", 32'(line_data_out), 9);
        tick();
        chk("t8_c5_done", 32'(done), 1);
        chk("t8_c5_hit", 32'(hit), 1);
        tick();
        chk("t8_c6_ready", 32'(bus_ready), 1);
        chk("t8_c6_done", 32'(done), 0);
        tick();
        chk("t8_c7_ready", 32'(bus_ready), 1);
        chk("t8_c7_lw", 32'(line_write), 0);
        chk("t8_c7_done", 32'(done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
